// File: rtl/bridge_pkg.sv
// Shared types and constants for the parametrised ASCII bridge receiver.
// Error codes, FSM states and the ASCII bytes the parser keys on.
package bridge_pkg;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_BAD_CHAR = 3'd1,
    ERR_BAD_LEN  = 3'd2,
    ERR_TIMEOUT  = 3'd3,
    ERR_OVERFLOW = 3'd4
  } err_code_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    DATA     = 3'd2,
    EOL_WAIT = 3'd3,
    DISCARD  = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_W  = 8'h57;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic logic is_eol(input logic [7:0] c);
    return (c == ASCII_CR) || (c == ASCII_LF);
  endfunction

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII hex digit decoder: accepts 0-9, A-F and a-f.
// For letters the low nibble of the code plus 9 gives the digit value.
module hex_ascii_decode (
  input  logic [7:0] ch,
  output logic [3:0] nibble,
  output logic       is_hex
);

  always_comb begin
    nibble = 4'd0;
    is_hex = 1'b0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      nibble = ch[3:0];
      is_hex = 1'b1;
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      nibble = ch[3:0] + 4'd9;
      is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/bridge_rx_param.sv
// Parses "R<addr>EOL" / "W<addr><data>EOL" ASCII streams into bus transactions,
// with held valid/ready output, coded error pulses and an optional idle timeout.
module bridge_rx_param
  import bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            data_i,
  input  logic                  valid_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  rw_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  err_o,
  output logic [2:0]            err_code_o
);

  localparam int ADDR_CHARS = ADDR_WIDTH / 4;
  localparam int DATA_CHARS = DATA_WIDTH / 4;
  localparam int MAX_CHARS  = (ADDR_CHARS > DATA_CHARS) ? ADDR_CHARS : DATA_CHARS;
  localparam int CNT_W      = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam int TO_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        char_cnt;
  logic [ADDR_WIDTH-1:0]   addr_sr;
  logic [DATA_WIDTH-1:0]   data_sr;
  logic                    rw_sr;
  logic [TO_W-1:0]         idle_cnt;
  logic [3:0]              nibble;
  logic                    is_hex, eol, start, active;
  logic                    addr_last, data_last, commit, timeout_hit, fsm_err;
  err_code_t               fsm_code;

  hex_ascii_decode u_hex (
    .ch    (data_i),
    .nibble(nibble),
    .is_hex(is_hex)
  );

  assign eol         = is_eol(data_i);
  assign start       = (data_i == ASCII_R) || (data_i == ASCII_W);
  assign active      = (state == ADDR) || (state == DATA) || (state == EOL_WAIT);
  assign addr_last   = (char_cnt == CNT_W'(ADDR_CHARS - 1));
  assign data_last   = (char_cnt == CNT_W'(DATA_CHARS - 1));
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && active && !valid_i &&
                       (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nx = state;
    fsm_err  = 1'b0;
    fsm_code = ERR_NONE;
    commit   = 1'b0;
    if (valid_i) begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nx = ADDR;
          end else if (!eol) begin
            state_nx = DISCARD;
            fsm_err  = 1'b1;
            fsm_code = ERR_BAD_CHAR;
          end
        end
        ADDR, DATA: begin
          if (is_hex) begin
            if (state == ADDR && addr_last) state_nx = rw_sr ? DATA : EOL_WAIT;
            else if (state == DATA && data_last) state_nx = EOL_WAIT;
          end else if (eol) begin
            state_nx = IDLE;
            fsm_err  = 1'b1;
            fsm_code = ERR_BAD_LEN;
          end else begin
            state_nx = DISCARD;
            fsm_err  = 1'b1;
            fsm_code = ERR_BAD_CHAR;
          end
        end
        EOL_WAIT: begin
          if (eol) begin
            state_nx = IDLE;
            commit   = 1'b1;
          end else begin
            state_nx = DISCARD;
            fsm_err  = 1'b1;
            fsm_code = is_hex ? ERR_BAD_LEN : ERR_BAD_CHAR;
          end
        end
        DISCARD: if (eol) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_nx = IDLE;
      fsm_err  = 1'b1;
      fsm_code = ERR_TIMEOUT;
    end
  end

  // A commit that meets an unaccepted transaction is dropped as OVERFLOW;
  // one that coincides with the handshake replaces it without a gap in valid_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      char_cnt   <= '0;
      addr_sr    <= '0;
      data_sr    <= '0;
      rw_sr      <= 1'b0;
      idle_cnt   <= '0;
      addr_o     <= '0;
      data_o     <= '0;
      rw_o       <= 1'b0;
      valid_o    <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= ERR_NONE;
    end else begin
      state <= state_nx;
      err_o <= 1'b0;
      if (fsm_err) begin
        err_o      <= 1'b1;
        err_code_o <= fsm_code;
      end

      if (TIMEOUT_CYCLES == 0 || valid_i || !active || timeout_hit) idle_cnt <= '0;
      else idle_cnt <= idle_cnt + 1'b1;

      if (timeout_hit || (valid_i && state == IDLE && start)) begin
        addr_sr  <= '0;
        data_sr  <= '0;
        char_cnt <= '0;
      end
      if (valid_i && state == IDLE && start) rw_sr <= (data_i == ASCII_W);

      if (valid_i && is_hex && state == ADDR) begin
        addr_sr  <= (addr_sr << 4) | ADDR_WIDTH'(nibble);
        char_cnt <= addr_last ? '0 : char_cnt + 1'b1;
      end
      if (valid_i && is_hex && state == DATA) begin
        data_sr  <= (data_sr << 4) | DATA_WIDTH'(nibble);
        char_cnt <= data_last ? '0 : char_cnt + 1'b1;
      end

      if (commit) begin
        if (valid_o && !ready_i) begin
          err_o      <= 1'b1;
          err_code_o <= ERR_OVERFLOW;
        end else begin
          valid_o <= 1'b1;
          addr_o  <= addr_sr;
          data_o  <= rw_sr ? data_sr : '0;
          rw_o    <= rw_sr;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bridge_rx_param.sv
// Self-checking bench: three bridge instances (default, 32/8 widths, timeout 20)
// driven by a vector table plus directed overflow, timeout and reset sequences.
module tb_bridge_rx_param;
  import bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [2:0]  vin = 3'b000;
  logic [2:0]  rdy = 3'b111;

  logic [15:0] addr0, data0, addr2, data2;
  logic [31:0] addr1;
  logic [7:0]  data1;
  logic        rw0, rw1, rw2, valid0, valid1, valid2, err0, err1, err2;
  logic [2:0]  code0, code1, code2;

  always #5 clk = ~clk;

  bridge_rx_param dut0 (
    .clk(clk), .rst_n(rst_n), .data_i(din), .valid_i(vin[0]),
    .addr_o(addr0), .data_o(data0), .rw_o(rw0), .valid_o(valid0),
    .ready_i(rdy[0]), .err_o(err0), .err_code_o(code0)
  );

  bridge_rx_param #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_i(din), .valid_i(vin[1]),
    .addr_o(addr1), .data_o(data1), .rw_o(rw1), .valid_o(valid1),
    .ready_i(rdy[1]), .err_o(err1), .err_code_o(code1)
  );

  bridge_rx_param #(.TIMEOUT_CYCLES(20)) dut2 (
    .clk(clk), .rst_n(rst_n), .data_i(din), .valid_i(vin[2]),
    .addr_o(addr2), .data_o(data2), .rw_o(rw2), .valid_o(valid2),
    .ready_i(rdy[2]), .err_o(err2), .err_code_o(code2)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  int          hs_cnt[3];
  int          err_cnt[3];
  logic [31:0] cap_addr[3];
  logic [31:0] cap_data[3];
  logic        cap_rw[3];

  // Running totals of accepted transactions and error pulses per instance
  always @(negedge clk) begin
    if (valid0 && rdy[0]) begin
      hs_cnt[0]++; cap_addr[0] = 32'(addr0); cap_data[0] = 32'(data0); cap_rw[0] = rw0;
    end
    if (valid1 && rdy[1]) begin
      hs_cnt[1]++; cap_addr[1] = addr1; cap_data[1] = 32'(data1); cap_rw[1] = rw1;
    end
    if (valid2 && rdy[2]) begin
      hs_cnt[2]++; cap_addr[2] = 32'(addr2); cap_data[2] = 32'(data2); cap_rw[2] = rw2;
    end
    if (err0) err_cnt[0]++;
    if (err1) err_cnt[1]++;
    if (err2) err_cnt[2]++;
  end

  typedef struct {
    int          dut;
    string       msg;
    int          hs;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    int          errs;
    logic [2:0]  code;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [2:0] code_of(input int d);
    return (d == 0) ? code0 : (d == 1) ? code1 : code2;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input int d, input string s);
    for (int i = 0; i < s.len(); i++) begin
      din    = s[i];
      vin[d] = 1'b1;
      @(negedge clk);
    end
    vin[d] = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
    #2;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int h, e, first;

    vecs[0]  = '{0, "W12345678\r\n",       1, 32'h1234,     32'h5678, 1'b1, 0, 3'd0};
    vecs[1]  = '{0, "RABC\r\n",            0, 32'h0,        32'h0,    1'b0, 1, 3'd2};
    vecs[2]  = '{0, "RABCG\r\n",           0, 32'h0,        32'h0,    1'b0, 1, 3'd1};
    vecs[3]  = '{0, "R1234\n",             1, 32'h1234,     32'h0,    1'b0, 0, 3'd1};
    vecs[4]  = '{0, "Rab0F\n",             1, 32'hAB0F,     32'h0,    1'b0, 0, 3'd1};
    vecs[5]  = '{0, "R12345\n",            0, 32'h0,        32'h0,    1'b0, 1, 3'd2};
    vecs[6]  = '{0, "X\r\n",               0, 32'h0,        32'h0,    1'b0, 1, 3'd1};
    vecs[7]  = '{0, "W1234\n",             0, 32'h0,        32'h0,    1'b0, 1, 3'd2};
    vecs[8]  = '{0, "R1234Q\n",            0, 32'h0,        32'h0,    1'b0, 1, 3'd1};
    vecs[9]  = '{0, "QZZZ\nWffff0001\r",   1, 32'hFFFF,     32'h0001, 1'b1, 1, 3'd1};
    vecs[10] = '{0, "\n\rW00009abc\r\n",   1, 32'h0000,     32'h9ABC, 1'b1, 0, 3'd1};
    vecs[11] = '{1, "Wdeadbeef5a\n",       1, 32'hDEADBEEF, 32'h5A,   1'b1, 0, 3'd0};
    vecs[12] = '{1, "R0000BABE\r",         1, 32'h0000BABE, 32'h0,    1'b0, 0, 3'd0};
    vecs[13] = '{1, "RBABE\n",             0, 32'h0,        32'h0,    1'b0, 1, 3'd2};
    vecs[14] = '{1, "W12345678G\n",        0, 32'h0,        32'h0,    1'b0, 1, 3'd1};

    repeat (3) @(negedge clk);
    check_output("rst_addr",  32'(addr0),  32'h0);
    check_output("rst_data",  32'(data0),  32'h0);
    check_output("rst_rw",    32'(rw0),    32'h0);
    check_output("rst_valid", 32'(valid0), 32'h0);
    check_output("rst_err",   32'(err0),   32'h0);
    check_output("rst_code",  32'(code0),  32'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 15; k++) begin
      int d;
      d = vecs[k].dut;
      h = hs_cnt[d];
      e = err_cnt[d];
      apply_stimulus(d, vecs[k].msg);
      settle();
      check_output($sformatf("v%0d_hs", k),   32'(hs_cnt[d] - h),  32'(vecs[k].hs));
      check_output($sformatf("v%0d_errs", k), 32'(err_cnt[d] - e), 32'(vecs[k].errs));
      check_output($sformatf("v%0d_code", k), 32'(code_of(d)),     32'(vecs[k].code));
      if (vecs[k].hs > 0) begin
        check_output($sformatf("v%0d_addr", k), cap_addr[d],     vecs[k].addr);
        check_output($sformatf("v%0d_data", k), cap_data[d],     vecs[k].data);
        check_output($sformatf("v%0d_rw", k),   32'(cap_rw[d]),  32'(vecs[k].rw));
      end
    end

    // Held output, overflow, release, then commit coinciding with the handshake
    rdy[0] = 1'b0;
    apply_stimulus(0, "R1111\n");
    settle();
    check_output("hold_valid", 32'(valid0), 32'h1);
    check_output("hold_addr",  32'(addr0),  32'h1111);
    e = err_cnt[0];
    apply_stimulus(0, "R2222\n");
    settle();
    check_output("ovf_errs",  32'(err_cnt[0] - e), 32'h1);
    check_output("ovf_code",  32'(code0),  32'(ERR_OVERFLOW));
    check_output("ovf_valid", 32'(valid0), 32'h1);
    check_output("ovf_addr",  32'(addr0),  32'h1111);
    rdy[0] = 1'b1;
    @(negedge clk);
    check_output("release_valid", 32'(valid0), 32'h0);

    rdy[0] = 1'b0;
    apply_stimulus(0, "R3333\n");
    settle();
    check_output("hold2_addr", 32'(addr0), 32'h3333);
    apply_stimulus(0, "W4444abcd");
    din    = ASCII_LF;
    vin[0] = 1'b1;
    rdy[0] = 1'b1;
    @(negedge clk);
    vin[0] = 1'b0;
    check_output("swap_valid", 32'(valid0), 32'h1);
    check_output("swap_addr",  32'(addr0),  32'h4444);
    check_output("swap_data",  32'(data0),  32'hABCD);
    check_output("swap_err",   32'(err0),   32'h0);
    @(negedge clk);
    check_output("swap_drop",  32'(valid0), 32'h0);

    // Idle timeout mid-message on the timeout-enabled instance
    e = err_cnt[2];
    apply_stimulus(2, "R12");
    first = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (err2) begin
        first = c;
        break;
      end
    end
    check_output("to_cycle", 32'(first), 32'd20);
    #2;
    check_output("to_errs", 32'(err_cnt[2] - e), 32'h1);
    check_output("to_code", 32'(code2), 32'(ERR_TIMEOUT));
    e = err_cnt[2];
    apply_stimulus(2, "34\n");
    settle();
    check_output("to_tail_errs", 32'(err_cnt[2] - e), 32'h1);
    check_output("to_tail_code", 32'(code2), 32'(ERR_BAD_CHAR));
    h = hs_cnt[2];
    apply_stimulus(2, "R5678\n");
    settle();
    check_output("to_next_hs",   32'(hs_cnt[2] - h), 32'h1);
    check_output("to_next_addr", cap_addr[2], 32'h5678);

    // Reset in the middle of a message
    apply_stimulus(0, "W1234");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_output("mrst_addr",  32'(addr0),  32'h0);
    check_output("mrst_data",  32'(data0),  32'h0);
    check_output("mrst_rw",    32'(rw0),    32'h0);
    check_output("mrst_valid", 32'(valid0), 32'h0);
    check_output("mrst_code",  32'(code0),  32'h0);
    rst_n = 1'b1;
    h = hs_cnt[0];
    e = err_cnt[0];
    repeat (5) @(negedge clk);
    #2;
    check_output("mrst_quiet_hs",   32'(hs_cnt[0] - h),  32'h0);
    check_output("mrst_quiet_errs", 32'(err_cnt[0] - e), 32'h0);
    apply_stimulus(0, "R00FF\n");
    settle();
    check_output("mrst_next_hs",   32'(hs_cnt[0] - h), 32'h1);
    check_output("mrst_next_addr", cap_addr[0], 32'h00FF);
    check_output("mrst_next_rw",   32'(cap_rw[0]), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
